// File: rtl/line_cmd_sequencer.sv
// Line command sequencer: queues CPU line-draw commands and replays each one onto the line engine.
// Latency: push at edge t -> colour strobe at t+2, trigger at t+7 (t+6 on a colour-cache hit); all outputs registered.
// Backpressure: cmd_ready drops while the FIFO holds DEPTH commands; a command starts only when line_ready is high in IDLE.
//
// Ports:
//   clk, rst_n            CPU clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake; cmd_x0/y0/x1/y1, cmd_color carry the command
//   flush                 discard queued commands that have not started yet
//   line_ready            line engine idle
//   line_color/point      data buses to the engine, qualified by the *_valid strobes and line_trigger
//   busy, pending, done   status: work outstanding, FIFO occupancy, one pulse per finished line
module line_cmd_sequencer #(
    parameter int DEPTH = 4,
    parameter int PW    = 10,
    parameter int CW    = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [PW-1:0]          cmd_x0,
    input  logic [PW-1:0]          cmd_y0,
    input  logic [PW-1:0]          cmd_x1,
    input  logic [PW-1:0]          cmd_y1,
    input  logic [CW-1:0]          cmd_color,
    input  logic                   flush,
    input  logic                   line_ready,
    output logic [CW-1:0]          line_color,
    output logic [PW-1:0]          line_point,
    output logic                   line_color_valid,
    output logic                   line_x0_valid,
    output logic                   line_y0_valid,
    output logic                   line_x1_valid,
    output logic                   line_y1_valid,
    output logic                   line_trigger,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] pending,
    output logic                   done
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef struct packed {
        logic [CW-1:0] color;
        logic [PW-1:0] x0;
        logic [PW-1:0] y0;
        logic [PW-1:0] x1;
        logic [PW-1:0] y1;
    } cmd_t;

    typedef enum logic [3:0] {
        S_IDLE, S_COLOR, S_X0, S_Y0, S_X1, S_Y1, S_TRIG, S_ACK, S_DRAW
    } state_t;

    cmd_t          mem [DEPTH];
    cmd_t          cmd_in;
    cmd_t          head;
    cmd_t          work_q;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   pending_nxt;
    logic          push;
    logic          pop;
    state_t        state;
    state_t        state_nxt;
    logic          cache_vld;
    logic [CW-1:0] cache_color;

    assign cmd_in = {cmd_color, cmd_x0, cmd_y0, cmd_x1, cmd_y1};
    assign head   = mem[rd_ptr];

    // cmd_ready is the registered "not full" flag, so a full FIFO never
    // accepts even when a pop happens in the same cycle. A push that
    // coincides with flush is dropped.
    assign push = cmd_valid & cmd_ready & ~flush;

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            S_IDLE: begin
                if (pending != '0 && line_ready && !flush) begin
                    pop = 1'b1;
                    // Skip the colour strobe when the engine already holds this colour.
                    state_nxt = (cache_vld && cache_color == head.color) ? S_X0 : S_COLOR;
                end
            end
            S_COLOR: state_nxt = S_X0;
            S_X0:    state_nxt = S_Y0;
            S_Y0:    state_nxt = S_X1;
            S_X1:    state_nxt = S_Y1;
            S_Y1:    state_nxt = S_TRIG;
            S_TRIG:  state_nxt = S_ACK;
            // The engine lowers line_ready only one cycle after the trigger,
            // so ready is not trusted until DRAW.
            S_ACK:   state_nxt = S_DRAW;
            S_DRAW:  if (line_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        pending_nxt = pending;
        if (flush) begin
            pending_nxt = '0;
        end else if (push && !pop) begin
            pending_nxt = pending + (AW+1)'(1);
        end else if (pop && !push) begin
            pending_nxt = pending - (AW+1)'(1);
        end
    end

    // FIFO storage carries no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= cmd_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= S_IDLE;
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            pending          <= '0;
            cmd_ready        <= 1'b0;
            busy             <= 1'b0;
            work_q           <= '0;
            cache_vld        <= 1'b0;
            cache_color      <= '0;
            line_color       <= '0;
            line_point       <= '0;
            line_color_valid <= 1'b0;
            line_x0_valid    <= 1'b0;
            line_y0_valid    <= 1'b0;
            line_x1_valid    <= 1'b0;
            line_y1_valid    <= 1'b0;
            line_trigger     <= 1'b0;
            done             <= 1'b0;
        end else begin
            state     <= state_nxt;
            pending   <= pending_nxt;
            cmd_ready <= (pending_nxt != FULL);
            busy      <= (state_nxt != S_IDLE) || (pending_nxt != '0);

            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (flush) begin
                rd_ptr <= wr_ptr;
            end else if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                work_q <= head;
            end

            // Strobes follow the state by one register stage; the buses
            // only change alongside their strobe and hold otherwise.
            line_color_valid <= (state == S_COLOR);
            line_x0_valid    <= (state == S_X0);
            line_y0_valid    <= (state == S_Y0);
            line_x1_valid    <= (state == S_X1);
            line_y1_valid    <= (state == S_Y1);
            line_trigger     <= (state == S_TRIG);
            done             <= (state == S_DRAW) && line_ready;

            if (state == S_COLOR) begin
                line_color  <= work_q.color;
                cache_color <= work_q.color;
                cache_vld   <= 1'b1;
            end
            if (state == S_X0) line_point <= work_q.x0;
            if (state == S_Y0) line_point <= work_q.y0;
            if (state == S_X1) line_point <= work_q.x1;
            if (state == S_Y1) line_point <= work_q.y1;
        end
    end

endmodule

// File: tb/tb_line_cmd_sequencer.sv
`timescale 1ns/1ps
module tb_line_cmd_sequencer;

    localparam int DEPTH = 4;
    localparam int PW    = 10;
    localparam int CW    = 32;

    localparam int K_COLOR = 0;
    localparam int K_X0    = 1;
    localparam int K_Y0    = 2;
    localparam int K_X1    = 3;
    localparam int K_Y1    = 4;
    localparam int K_TRIG  = 5;
    localparam int K_DONE  = 6;

    typedef struct {
        int          kind;
        logic [31:0] val;
    } ev_t;

    logic                   clk;
    logic                   rst_n;
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic [PW-1:0]          cmd_x0;
    logic [PW-1:0]          cmd_y0;
    logic [PW-1:0]          cmd_x1;
    logic [PW-1:0]          cmd_y1;
    logic [CW-1:0]          cmd_color;
    logic                   flush;
    logic                   line_ready;
    logic [CW-1:0]          line_color;
    logic [PW-1:0]          line_point;
    logic                   line_color_valid;
    logic                   line_x0_valid;
    logic                   line_y0_valid;
    logic                   line_x1_valid;
    logic                   line_y1_valid;
    logic                   line_trigger;
    logic                   busy;
    logic [$clog2(DEPTH):0] pending;
    logic                   done;

    line_cmd_sequencer #(.DEPTH(DEPTH), .PW(PW), .CW(CW)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_x0           (cmd_x0),
        .cmd_y0           (cmd_y0),
        .cmd_x1           (cmd_x1),
        .cmd_y1           (cmd_y1),
        .cmd_color        (cmd_color),
        .flush            (flush),
        .line_ready       (line_ready),
        .line_color       (line_color),
        .line_point       (line_point),
        .line_color_valid (line_color_valid),
        .line_x0_valid    (line_x0_valid),
        .line_y0_valid    (line_y0_valid),
        .line_x1_valid    (line_x1_valid),
        .line_y1_valid    (line_y1_valid),
        .line_trigger     (line_trigger),
        .busy             (busy),
        .pending          (pending),
        .done             (done)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int cyc      = 0;

    ev_t exp_q[$];
    bit          m_cache_vld = 0;
    logic [31:0] m_cache     = '0;

    int n_color = 0, n_trig = 0, n_done = 0;
    int col_cyc = 0, trig_cyc = 0, done_cyc = 0;

    bit force_low = 0;
    bit rand_draw = 0;
    int draw_len  = 10;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic check_ev(input int kind, input logic [31:0] val);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_event: got kind %0d val %0h, required no event (cycle %0d)", kind, val, cyc);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", kind, e.kind);
            chk("event_val", val, e.val);
        end
    endtask

    // Monitor: every strobe or done pulse is matched against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            int ns;
            ns = int'(line_color_valid) + int'(line_x0_valid) + int'(line_y0_valid) +
                 int'(line_x1_valid) + int'(line_y1_valid) + int'(line_trigger);
            if (ns != 0) chk("single_strobe", ns, 1);
            if (line_color_valid) begin
                n_color++;
                col_cyc = cyc;
                check_ev(K_COLOR, line_color);
            end
            if (line_x0_valid) check_ev(K_X0, 32'(line_point));
            if (line_y0_valid) check_ev(K_Y0, 32'(line_point));
            if (line_x1_valid) check_ev(K_X1, 32'(line_point));
            if (line_y1_valid) check_ev(K_Y1, 32'(line_point));
            if (line_trigger) begin
                n_trig++;
                trig_cyc = cyc;
                chk("trig_with_ready", line_ready, 1);
                check_ev(K_TRIG, 0);
            end
            if (done) begin
                n_done++;
                done_cyc = cyc;
                check_ev(K_DONE, 0);
            end
        end
    end

    // Engine model: drops ready the cycle after a trigger, raises it after the draw time.
    initial begin
        int dl;
        line_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (line_trigger) begin
                @(posedge clk);
                #1 line_ready = 1'b0;
                dl = rand_draw ? int'($urandom_range(1, 6)) : draw_len;
                repeat (dl) @(posedge clk);
                #1 line_ready = !force_low;
            end else begin
                @(posedge clk);
                #1 line_ready = !force_low;
            end
        end
    end

    task automatic exp_push(input int kind, input logic [31:0] val);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic model_expect(input logic [PW-1:0] x0, y0, x1, y1, input logic [CW-1:0] col);
        if (!m_cache_vld || m_cache != col) exp_push(K_COLOR, col);
        m_cache     = col;
        m_cache_vld = 1;
        exp_push(K_X0, 32'(x0));
        exp_push(K_Y0, 32'(y0));
        exp_push(K_X1, 32'(x1));
        exp_push(K_Y1, 32'(y1));
        exp_push(K_TRIG, 0);
        exp_push(K_DONE, 0);
    endtask

    task automatic push_cmd(input logic [PW-1:0] x0, y0, x1, y1, input logic [CW-1:0] col,
                            input bit will_run, input int budget, output bit accepted, output int t);
        int n;
        accepted = 0;
        t        = 0;
        n        = 0;
        @(negedge clk);
        cmd_x0    = x0;
        cmd_y0    = y0;
        cmd_x1    = x1;
        cmd_y1    = y1;
        cmd_color = col;
        cmd_valid = 1'b1;
        while (!accepted && n < budget) begin
            if (cmd_ready) begin
                @(posedge clk);
                #1;
                accepted = 1;
                t        = cyc;
            end else begin
                @(negedge clk);
                n++;
            end
        end
        cmd_valid = 1'b0;
        if (accepted && will_run) model_expect(x0, y0, x1, y1, col);
    endtask

    task automatic push_run(input logic [PW-1:0] x0, y0, x1, y1, input logic [CW-1:0] col,
                            input bit will_run, output int t);
        bit acc;
        push_cmd(x0, y0, x1, y1, col, will_run, 300, acc, t);
        chk("push_accept", acc, 1);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n;
        n = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || busy || !line_ready) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, (n < budget), 1);
    endtask

    logic [31:0] pal [4] = '{32'h00FF0000, 32'h0000FF00, 32'h000000FF, 32'h00FFFFFF};

    initial begin
        int  t, c0, t0, d0, n;
        bit  acc;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_x0    = '0;
        cmd_y0    = '0;
        cmd_x1    = '0;
        cmd_y1    = '0;
        cmd_color = '0;
        flush     = 1'b0;

        // Reset state
        #12;
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_pending", pending, 0);
        chk("rst_busy", busy, 0);
        chk("rst_trigger", line_trigger, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_cmd_ready", cmd_ready, 1);
        chk("post_rst_busy", busy, 0);

        // Single command, full colour sequence and latency
        draw_len = 10;
        push_run(10'd5, 10'd6, 10'd100, 10'd200, 32'h00FF0000, 1, t);
        wait_idle(200, "t1_idle");
        chk("t1_color_cycle", col_cyc, t + 2);
        chk("t1_trig_cycle", trig_cyc, t + 7);
        chk("t1_done_cycle", done_cyc, t + 19);
        chk("t1_done_count", n_done, 1);

        // Colour cache: repeat colour skips strobe, new colour re-issues it
        c0 = n_color;
        t0 = n_trig;
        draw_len = 3;
        push_run(10'd1, 10'd2, 10'd3, 10'd4, 32'h12345678, 1, t);
        push_run(10'd11, 10'd12, 10'd13, 10'd14, 32'h12345678, 1, t);
        push_run(10'd21, 10'd22, 10'd23, 10'd24, 32'h0000FF00, 1, t);
        wait_idle(300, "t2_idle");
        chk("t2_color_strobes", n_color - c0, 2);
        chk("t2_triggers", n_trig - t0, 3);
        c0 = n_color;
        push_run(10'd1023, 10'd0, 10'd512, 10'd511, 32'h0000FF00, 1, t);
        wait_idle(200, "t2_hit_idle");
        chk("t2_hit_trig_cycle", trig_cyc, t + 6);
        chk("t2_hit_no_color", n_color - c0, 0);

        // Fill FIFO while engine busy; fifth command refused
        force_low = 1;
        repeat (2) @(negedge clk);
        d0 = n_done;
        for (int i = 0; i < 4; i++) begin
            push_run(PW'(30 + i), PW'(40 + i), PW'(50 + i), PW'(60 + i), pal[i], 1, t);
        end
        push_cmd(10'd99, 10'd99, 10'd99, 10'd99, 32'hDEADBEEF, 1, 5, acc, t);
        chk("t3_fifth_refused", acc, 0);
        chk("t3_cmd_ready_full", cmd_ready, 0);
        chk("t3_pending_full", pending, 4);
        chk("t3_busy", busy, 1);
        force_low = 0;
        wait_idle(500, "t3_idle");
        chk("t3_done_count", n_done - d0, 4);

        // Flush while first command draws
        draw_len = 10;
        t0 = n_trig;
        d0 = n_done;
        push_run(10'd7, 10'd8, 10'd9, 10'd10, 32'h00AA5500, 1, t);
        push_run(10'd70, 10'd80, 10'd90, 10'd100, 32'h00AA5501, 0, t);
        push_run(10'd71, 10'd81, 10'd91, 10'd101, 32'h00AA5502, 0, t);
        n = 0;
        @(negedge clk);
        while (line_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t4_reach_draw", (n < 50), 1);
        chk("t4_pending_before", pending, 2);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        chk("t4_pending_flushed", pending, 0);
        chk("t4_cmd_ready", cmd_ready, 1);
        wait_idle(200, "t4_idle");
        repeat (10) @(negedge clk);
        chk("t4_one_trigger", n_trig - t0, 1);
        chk("t4_one_done", n_done - d0, 1);
        chk("t4_busy", busy, 0);

        // Reset in the middle of a sequence
        draw_len = 3;
        push_run(10'd300, 10'd301, 10'd302, 10'd303, 32'h00ABCDEF, 1, t);
        n = 0;
        @(negedge clk);
        while (!line_y0_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t5_reach_y0", (n < 50), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("t5_y0_cleared", line_y0_valid, 0);
        chk("t5_point_cleared", line_point, 0);
        chk("t5_pending", pending, 0);
        chk("t5_busy", busy, 0);
        chk("t5_cmd_ready", cmd_ready, 0);
        exp_q.delete();
        m_cache_vld = 0;
        t0 = n_trig;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("t5_no_trigger_after_rst", n_trig - t0, 0);
        c0 = n_color;
        push_run(10'd400, 10'd401, 10'd402, 10'd403, 32'h00ABCDEF, 1, t);
        wait_idle(200, "t5_idle");
        chk("t5_color_reissued", n_color - c0, 1);

        // Random stress
        rand_draw = 1;
        d0 = n_done;
        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            push_run(PW'($urandom_range(0, 1023)), PW'($urandom_range(0, 1023)),
                     PW'($urandom_range(0, 1023)), PW'($urandom_range(0, 1023)),
                     pal[$urandom_range(0, 3)], 1, t);
        end
        wait_idle(3000, "t6_idle");
        chk("t6_done_count", n_done - d0, 1000);
        chk("t6_queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/line_cmd_sequencer.md
Name: line_cmd_sequencer

Overview:
- Queues line-draw commands (endpoints plus colour) written by the CPU.
- Sequences each command onto the line-engine programming interface of the memory/video subsystem: colour, x0, y0, x1 and y1 strobes, then trigger, then waits for completion.
- Sits between Riscv151 MMIO decode and the Memory151 line-engine ports, so software no longer polls line_ready between register writes.

Parameters:
DEPTH, 4, command FIFO entries; power of two, >= 2
PW, 10, coordinate width, matches line_point
CW, 32, colour width, matches line_color

Ports:
clk  in  1  CPU clock (cpu_clk_g domain)
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  FIFO can accept a command
cmd_x0  in  PW  start x
cmd_y0  in  PW  start y
cmd_x1  in  PW  end x
cmd_y1  in  PW  end y
cmd_color  in  CW  line colour
flush  in  1  synchronous discard of queued, not-yet-started commands
line_ready  in  1  line engine idle
line_color  out  CW  colour to engine
line_point  out  PW  coordinate to engine
line_color_valid  out  1  colour strobe
line_x0_valid  out  1  x0 strobe
line_y0_valid  out  1  y0 strobe
line_x1_valid  out  1  x1 strobe
line_y1_valid  out  1  y1 strobe
line_trigger  out  1  start-draw strobe
busy  out  1  command in flight or FIFO non-empty
pending  out  $clog2(DEPTH)+1  FIFO occupancy
done  out  1  one-cycle pulse per completed line

Behaviour:
Reset:
- rst_n low forces, asynchronously, every output to 0, except cmd_ready, which goes to 0 during reset and to 1 on the first clock after release.
- Reset empties the FIFO, invalidates the colour cache and puts the FSM in IDLE.
- Reset mid-sequence abandons the command; no further strobes are issued.

Outputs and FIFO:
- All outputs are registered.
- cmd_ready = (pending != DEPTH), registered.
- Push on cmd_valid & cmd_ready. When full, no push occurs even if a pop happens in the same cycle.
- pending increments on push, decrements on pop, and is unchanged on simultaneous push and pop.
- flush: pending becomes 0 next cycle and read/write pointers are equalised. A push in the flush cycle is dropped. The in-flight command completes normally.

FSM states: IDLE, COLOR, X0, Y0, X1, Y1, TRIG, ACK, DRAW.
- IDLE: if pending != 0 and line_ready and not flush, pop the head into working registers. Next state is COLOR, or X0 if the colour cache is valid and equal to the head colour.
- COLOR: line_color_valid = 1 and line_color = colour, for one cycle; update the colour cache; go to X0.
- X0, Y0, X1, Y1: the matching *_valid = 1 and line_point = coordinate, each for exactly one cycle, in that order.
- TRIG: line_trigger = 1 for one cycle; go to ACK.
- ACK: one cycle, ignores line_ready (engine drops ready the cycle after trigger); go to DRAW.
- DRAW: when line_ready = 1, pulse done for one cycle and return to IDLE. Strobes stay 0 throughout.

Strobe and bus rules:
- At most one strobe is high in any cycle.
- line_point and line_color hold their last value when no strobe is active.
- No strobe is issued while line_ready = 0, except inside the sequence itself.

Latency and timing:
- Command pushed at edge t into an empty FIFO with the engine ready: pop at t+1, COLOR at t+2, X0..Y1 at t+3..t+6, TRIG at t+7.
- With a colour-cache hit the sequence is one cycle shorter (TRIG at t+6).
- Back-to-back: the next IDLE pop occurs the cycle after done.
- busy = (state != IDLE) | (pending != 0).

Widths: coordinates pass through unmodified; no clamping or arithmetic.

Test Plan:
- Reset, push {x0=5,y0=6,x1=100,y1=200,color=32'h00FF0000} with line_ready=1 -> color strobe at t+2, point values 5, 6, 100, 200 on t+3..t+6, trigger at t+7; engine model drops ready for 10 cycles -> done pulses once when ready rises.
- Push the same colour twice -> second command skips COLOR, exactly 4 point strobes then trigger; a third command with colour 32'h0000FF00 re-issues the colour strobe.
- Push DEPTH+1=5 commands while line_ready=0 -> cmd_ready low after 4 pushes, pending=4, fifth not accepted; raise ready -> all 4 lines drawn in FIFO order, 4 done pulses.
- 3 commands queued, first in DRAW, assert flush -> pending=0 next cycle, first completes with done, no further triggers.
- Deassert rst_n during Y0 -> all strobes 0 immediately, pending=0, busy=0; after release a new command runs with its colour strobe issued (cache invalidated).
- Random push/ready stress (1000 commands) -> the scoreboard sees every command's values in order, never two strobes in one cycle, and never a trigger while line_ready=0 at IDLE exit.
